// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared operation-select constants for the JK synchronous counter
package jk_pkg;

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop bit with synchronous reset, enable and reset value
module jk_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            case ({i_j, i_k})
                2'b10:   r_q <= 1'b1;
                2'b01:   r_q <= 1'b0;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_sync_counter.sv
// rtl/jk_sync_counter.sv - modulo counter / loadable register built from per-bit JK cells
module jk_sync_counter #(
    parameter int     WIDTH     = 4,
    parameter longint MOD       = longint'(1) << WIDTH,
    parameter longint RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             tc,
    output logic             load_err
);

    import jk_pkg::*;

    localparam logic [63:0]      MOD_U   = 64'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || MOD > (longint'(1) << WIDTH)
            || RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_params
            $error("jk_sync_counter: illegal WIDTH/MOD/RESET_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_jk_next;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_flip;
    logic             w_err;
    logic             r_load_err;

    // Every mode resolves to a target state; out-of-range targets leave Q unchanged.
    always_comb begin
        w_jk_next = (j & ~w_q) | (~k & w_q);
        w_target  = w_q;
        w_err     = 1'b0;
        case (mode)
            MODE_JK: begin
                if (64'(w_jk_next) >= MOD_U) w_err = 1'b1;
                else                         w_target = w_jk_next;
            end
            MODE_UP:   w_target = (w_q == MAX_VAL) ? '0 : w_q + WIDTH'(1);
            MODE_DOWN: w_target = (w_q == '0) ? MAX_VAL : w_q - WIDTH'(1);
            MODE_LOAD: begin
                if (64'(d) >= MOD_U) w_err = 1'b1;
                else                 w_target = d;
            end
            default: w_target = w_q;
        endcase
    end

    // A bit toggles exactly where the target differs, so J=K=flip.
    assign w_flip = w_target ^ w_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
            jk_cell #(
                .RESET_VAL (RST_VEC[gi])
            ) u_cell (
                .i_clock (clock),
                .i_reset (reset),
                .i_en    (en),
                .i_j     (w_flip[gi]),
                .i_k     (w_flip[gi]),
                .o_q     (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset)   r_load_err <= 1'b0;
        else if (en) r_load_err <= w_err;
        else         r_load_err <= 1'b0;
    end

    assign Q        = w_q;
    assign Q_bar    = ~w_q;
    assign load_err = r_load_err;
    assign tc       = en && (((mode == MODE_UP) && (w_q == MAX_VAL)) ||
                             ((mode == MODE_DOWN) && (w_q == '0)));

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the register/counter width in bits (legal range 1..32).
REQ-002 The module SHALL have parameter MOD, default 2**WIDTH, giving the count modulus (legal range 2..2**WIDTH).
REQ-003 The module SHALL have parameter RESET_VAL, default 0, giving the reset value of Q; RESET_VAL >= MOD SHALL be an elaboration error.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clock.
REQ-005 Ports (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- en  in  1  update enable; 0 = hold all state
- mode  in  2  operation select (REQ-008)
- j  in  WIDTH  per-bit J inputs, used in JK mode
- k  in  WIDTH  per-bit K inputs, used in JK mode
- d  in  WIDTH  parallel load value
- Q  out  WIDTH  registered state
- Q_bar  out  WIDTH  bitwise complement of Q
- tc  out  1  terminal count, combinational
- load_err  out  1  registered one-cycle error pulse

Function
REQ-006 Q_bar SHALL equal ~Q at all times, including during and after reset.
REQ-007 With en=0, Q SHALL hold, load_err SHALL be 0 on the next edge, and tc SHALL be 0.
REQ-008 mode encoding, applied on a rising edge with en=1:
- 00 JK: each bit i follows JK semantics (j=0,k=0 hold; j=1,k=0 set; j=0,k=1 clear; j=1,k=1 toggle).
- 01 UP: Q increments; Q=MOD-1 wraps to 0.
- 10 DOWN: Q decrements; Q=0 wraps to MOD-1.
- 11 LOAD: Q takes d.
REQ-009 The update latency SHALL be one clock: the new Q is visible immediately after the edge on which the operation is sampled.
REQ-010 In LOAD mode, if d >= MOD, Q SHALL hold and load_err SHALL be 1 for exactly the following cycle.
REQ-011 In JK mode, if the computed next state is >= MOD, Q SHALL hold and load_err SHALL be 1 for exactly the following cycle.
REQ-012 load_err SHALL be 0 after any edge that applies a legal operation.
REQ-013 tc SHALL be 1 iff en=1 and either mode=01 with Q=MOD-1, or mode=10 with Q=0; tc SHALL be 0 in all other cases.
REQ-014 When MOD=2**WIDTH, wrap-around SHALL equal natural binary overflow and underflow, and REQ-011 SHALL never fire.
REQ-015 Every Q bit SHALL be updated through a JK cell; for UP, DOWN and LOAD, the per-bit J/K SHALL be derived from the target next state (J=K=1 where the bit changes, J=K=0 where it does not).

Reset
REQ-016 When reset=1 on a rising edge, Q SHALL become RESET_VAL, Q_bar SHALL become ~RESET_VAL and load_err SHALL become 0, regardless of en, mode, j, k and d.
REQ-017 Reset asserted in the middle of a count or an error pulse SHALL abort that operation; no operation SHALL be applied on that edge.
REQ-018 On the first edge with reset=0, the sampled operation SHALL be applied normally from RESET_VAL.

Structure
REQ-019 A shared package jk_pkg SHALL hold the mode constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10 and MODE_LOAD=2'b11.
REQ-020 A sub-module jk_cell SHALL implement one JK flip-flop bit with synchronous reset, enable and reset value; jk_sync_counter SHALL instantiate WIDTH copies in a generate loop.
REQ-021 The next-state, range-check and tc logic SHALL reside in jk_sync_counter.

Verification (WIDTH=4, MOD=10, RESET_VAL=0 unless stated)
REQ-022 Reset then UP for 12 clocks -> Q sequence 1..9,0,1,2; tc=1 only while Q=9; Q_bar=~Q throughout.
REQ-023 Reset, then DOWN for 3 clocks -> Q=9,8,7; tc=1 in the cycle where Q=0 and mode=DOWN.
REQ-024 LOAD d=7 -> Q=7 with load_err=0; then LOAD d=12 -> Q stays 7 and load_err=1 for one cycle only.
REQ-025 JK mode from Q=0101 with j=0011 and k=0100 -> Q=0011; then j=1000, k=0000 -> next state 1011 (>=10), so Q holds at 0011 and load_err pulses; repeat with MOD=16 -> Q=1011.
REQ-026 UP with en toggling 1,0,1 and reset asserted while Q=5 -> Q=0 on that edge regardless of en; count resumes 1,2 afterwards; repeat with RESET_VAL=3 -> Q=3.
